// File: rtl/ifq_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifq_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 2;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC holding register: line address plus starting word offset.
// A redirect load wins over a line increment in the same cycle.
import ifq_fetch_pkg::*;

module fetch_pc_reg #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                load,
    input  logic [ADDR_W-1:2]   load_addr,
    output logic [ADDR_W-1:0]   pc_line,
    output logic [OFFSET_W-1:0] offset
);

    localparam logic [ADDR_W-1:0] RESET_LINE = ADDR_W'(RESET_PC) & ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [OFFSET_W-1:0] RESET_OFF = RESET_PC[3:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_line <= RESET_LINE;
            offset  <= RESET_OFF;
        end else if (load) begin
            pc_line <= {load_addr[ADDR_W-1:4], 4'b0000};
            offset  <= load_addr[3:2];
        end else if (inc) begin
            pc_line <= pc_line + ADDR_W'(LINE_BYTES);
            offset  <= '0;
        end
    end

endmodule

// File: rtl/ifq_fetch_ctrl.sv
// Fetch controller: one outstanding line read at a time, forwards returned
// lines into the IFQ, and flushes/restarts on a branch redirect.
//
// state  | meaning
// S_REQ  | idle at pc_line, issue a read when the IFQ has room
// S_WAIT | read outstanding, response is forwarded to the IFQ
// S_DROP | read outstanding but redirected, response is discarded
import ifq_fetch_pkg::*;

module ifq_fetch_ctrl #(
    parameter int          ADDR_W   = 32,
    parameter int          LINE_W   = 128,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ifq_full,
    input  logic [LINE_W-1:0]   i_cache_line,
    input  logic                i_cache_valid,
    input  logic                i_br_valid,
    input  logic [ADDR_W-1:0]   i_br_addr,
    output logic                o_cache_rd_en,
    output logic [ADDR_W-1:0]   o_cache_addr,
    output logic                o_ifq_wr_en,
    output logic [LINE_W-1:0]   o_ifq_wr_line,
    output logic [1:0]          o_ifq_offset,
    output logic                o_ifq_flush,
    output logic [ADDR_W-1:0]   o_fetch_pc
);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [ADDR_W-1:0]     pc_line;
    logic [OFFSET_W-1:0]   offset;
    logic                  pc_inc;
    logic                  br_addr_unused;

    // Byte-within-word bits of the redirect target carry no information.
    assign br_addr_unused = ^i_br_addr[1:0];

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .inc       (pc_inc),
        .load      (i_br_valid),
        .load_addr (i_br_addr[ADDR_W-1:2]),
        .pc_line   (pc_line),
        .offset    (offset)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (!i_br_valid && !i_ifq_full) state_nxt = S_WAIT;
            end
            S_WAIT, S_DROP: begin
                if (i_cache_valid)   state_nxt = S_REQ;
                else if (i_br_valid) state_nxt = S_DROP;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        o_cache_rd_en = 1'b0;
        o_ifq_wr_en   = 1'b0;
        pc_inc        = 1'b0;
        case (state)
            S_REQ:  o_cache_rd_en = !i_ifq_full && !i_br_valid;
            S_WAIT: begin
                o_ifq_wr_en = i_cache_valid && !i_br_valid;
                pc_inc      = i_cache_valid && !i_br_valid;
            end
            default: ;
        endcase
    end

    assign o_ifq_flush   = i_br_valid;
    assign o_ifq_wr_line = i_cache_line;
    assign o_ifq_offset  = offset;
    assign o_cache_addr  = pc_line;
    assign o_fetch_pc    = pc_line | {{(ADDR_W-OFFSET_W-2){1'b0}}, offset, 2'b00};

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Directed vector bench for ifq_fetch_ctrl: per-cycle table plus a mid-flight reset sequence.
module tb_ifq_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_ifq_full;
    logic [127:0] i_cache_line;
    logic         i_cache_valid;
    logic         i_br_valid;
    logic [31:0]  i_br_addr;
    logic         o_cache_rd_en;
    logic [31:0]  o_cache_addr;
    logic         o_ifq_wr_en;
    logic [127:0] o_ifq_wr_line;
    logic [1:0]   o_ifq_offset;
    logic         o_ifq_flush;
    logic [31:0]  o_fetch_pc;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ifq_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_ifq_full    (i_ifq_full),
        .i_cache_line  (i_cache_line),
        .i_cache_valid (i_cache_valid),
        .i_br_valid    (i_br_valid),
        .i_br_addr     (i_br_addr),
        .o_cache_rd_en (o_cache_rd_en),
        .o_cache_addr  (o_cache_addr),
        .o_ifq_wr_en   (o_ifq_wr_en),
        .o_ifq_wr_line (o_ifq_wr_line),
        .o_ifq_offset  (o_ifq_offset),
        .o_ifq_flush   (o_ifq_flush),
        .o_fetch_pc    (o_fetch_pc)
    );

    typedef struct {
        logic        full;
        logic        cv;
        int          lsel;
        logic        br;
        logic [31:0] br_addr;
        logic        rd;
        logic [31:0] addr;
        logic        wr;
        logic        fl;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 33;
    vec_t         vecs [NV];
    logic [127:0] lines [8];

    task automatic chk(input string name, input int row, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    initial begin
        lines[0] = 128'h00000004_00000003_00000002_00000001;
        lines[1] = 128'h11111111_22222222_33333333_44444444;
        lines[2] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        lines[3] = 128'h0f0f0f0f_f0f0f0f0_a5a5a5a5_5a5a5a5a;
        lines[4] = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;
        lines[5] = 128'h00000013_00100093_00200113_00300193;
        lines[6] = 128'hffffffff_00000000_ffffffff_00000000;
        lines[7] = 128'h76543210_fedcba98_13579bdf_2468ace0;

        //           full cv lsel br br_addr        rd addr          wr fl pc
        vecs[0]  = '{0, 0, 0, 0, 32'h0,          1, 32'h00,       0, 0, 32'h00};
        vecs[1]  = '{0, 1, 0, 0, 32'h0,          0, 32'h00,       1, 0, 32'h00};
        vecs[2]  = '{0, 0, 0, 0, 32'h0,          1, 32'h10,       0, 0, 32'h10};
        vecs[3]  = '{0, 1, 1, 0, 32'h0,          0, 32'h10,       1, 0, 32'h10};
        vecs[4]  = '{0, 0, 0, 0, 32'h0,          1, 32'h20,       0, 0, 32'h20};
        vecs[5]  = '{0, 1, 2, 0, 32'h0,          0, 32'h20,       1, 0, 32'h20};
        vecs[6]  = '{0, 0, 0, 0, 32'h0,          1, 32'h30,       0, 0, 32'h30};
        vecs[7]  = '{0, 1, 3, 0, 32'h0,          0, 32'h30,       1, 0, 32'h30};
        vecs[8]  = '{1, 0, 0, 0, 32'h0,          0, 32'h40,       0, 0, 32'h40};
        vecs[9]  = '{1, 0, 0, 0, 32'h0,          0, 32'h40,       0, 0, 32'h40};
        vecs[10] = '{1, 0, 0, 0, 32'h0,          0, 32'h40,       0, 0, 32'h40};
        vecs[11] = '{1, 0, 0, 0, 32'h0,          0, 32'h40,       0, 0, 32'h40};
        vecs[12] = '{1, 0, 0, 0, 32'h0,          0, 32'h40,       0, 0, 32'h40};
        vecs[13] = '{0, 0, 0, 0, 32'h0,          1, 32'h40,       0, 0, 32'h40};
        vecs[14] = '{0, 0, 0, 0, 32'h0,          0, 32'h40,       0, 0, 32'h40};
        vecs[15] = '{0, 0, 0, 1, 32'h24,         0, 32'h40,       0, 1, 32'h40};
        vecs[16] = '{0, 0, 0, 0, 32'h0,          0, 32'h20,       0, 0, 32'h24};
        vecs[17] = '{0, 1, 4, 0, 32'h0,          0, 32'h20,       0, 0, 32'h24};
        vecs[18] = '{0, 0, 0, 0, 32'h0,          1, 32'h20,       0, 0, 32'h24};
        vecs[19] = '{0, 0, 0, 0, 32'h0,          0, 32'h20,       0, 0, 32'h24};
        vecs[20] = '{0, 1, 5, 0, 32'h0,          0, 32'h20,       1, 0, 32'h24};
        vecs[21] = '{0, 0, 0, 0, 32'h0,          1, 32'h30,       0, 0, 32'h30};
        vecs[22] = '{0, 1, 6, 1, 32'h107,        0, 32'h30,       0, 1, 32'h30};
        vecs[23] = '{0, 0, 0, 0, 32'h0,          1, 32'h100,      0, 0, 32'h104};
        vecs[24] = '{0, 1, 7, 0, 32'h0,          0, 32'h100,      1, 0, 32'h104};
        vecs[25] = '{1, 0, 0, 1, 32'hFFFF_FFF0,  0, 32'h110,      0, 1, 32'h110};
        vecs[26] = '{0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFF0, 0, 0, 32'hFFFF_FFF0};
        vecs[27] = '{0, 1, 0, 0, 32'h0,          0, 32'hFFFF_FFF0, 1, 0, 32'hFFFF_FFF0};
        vecs[28] = '{1, 0, 0, 0, 32'h0,          0, 32'h00,       0, 0, 32'h00};
        vecs[29] = '{0, 0, 0, 1, 32'h4B,         0, 32'h00,       0, 1, 32'h00};
        vecs[30] = '{0, 0, 0, 0, 32'h0,          1, 32'h40,       0, 0, 32'h48};
        vecs[31] = '{0, 1, 1, 0, 32'h0,          0, 32'h40,       1, 0, 32'h48};
        vecs[32] = '{1, 1, 2, 0, 32'h0,          0, 32'h50,       0, 0, 32'h50};

        rst = 1'b1;
        i_ifq_full = 1'b0;
        i_cache_line = '0;
        i_cache_valid = 1'b0;
        i_br_valid = 1'b0;
        i_br_addr = '0;
        #2;
        chk("reset_fetch_pc", -1, o_fetch_pc, 32'h0);
        chk("reset_cache_addr", -1, o_cache_addr, 32'h0);
        chk("reset_wr_en", -1, o_ifq_wr_en, 1'b0);
        chk("reset_flush", -1, o_ifq_flush, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            i_ifq_full    = vecs[i].full;
            i_cache_valid = vecs[i].cv;
            i_cache_line  = lines[vecs[i].lsel];
            i_br_valid    = vecs[i].br;
            i_br_addr     = vecs[i].br_addr;
            #1;
            chk("rd_en", i, o_cache_rd_en, vecs[i].rd);
            chk("cache_addr", i, o_cache_addr, vecs[i].addr);
            chk("wr_en", i, o_ifq_wr_en, vecs[i].wr);
            chk("flush", i, o_ifq_flush, vecs[i].fl);
            chk("fetch_pc", i, o_fetch_pc, vecs[i].pc);
            chk("offset", i, o_ifq_offset, vecs[i].pc[3:2]);
            if (vecs[i].wr) chk("wr_line", i, o_ifq_wr_line, lines[vecs[i].lsel]);
            @(negedge clk);
        end

        // Reset while a read is outstanding: controller returns to RESET_PC and requests again.
        i_ifq_full = 1'b0;
        i_cache_valid = 1'b0;
        i_br_valid = 1'b0;
        #1;
        chk("pre_rst_rd_en", 100, o_cache_rd_en, 1'b1);
        chk("pre_rst_addr", 100, o_cache_addr, 32'h50);
        @(negedge clk);
        #1;
        chk("wait_rd_en", 101, o_cache_rd_en, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_fetch_pc", 102, o_fetch_pc, 32'h0);
        chk("midrst_rd_en", 102, o_cache_rd_en, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_rd_en", 103, o_cache_rd_en, 1'b1);
        chk("postrst_addr", 103, o_cache_addr, 32'h0);
        @(negedge clk);
        i_cache_valid = 1'b1;
        i_cache_line = lines[3];
        #1;
        chk("postrst_wr_en", 104, o_ifq_wr_en, 1'b1);
        chk("postrst_wr_line", 104, o_ifq_wr_line, lines[3]);
        @(negedge clk);
        i_cache_valid = 1'b0;
        #1;
        chk("postrst_next_addr", 105, o_cache_addr, 32'h10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
